// File: rtl/bc_pkg.sv
// Shared definitions for the basic computer datapath: ALU op encodings and default width.
// Macro AC_E_UNIT_SUB_EN enables ALU_SUB as an arithmetic op.
package bc_pkg;

  localparam int AC_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_LDA  = 3'b010,
    ALU_CMA  = 3'b011,
    ALU_CIL  = 3'b100,
    ALU_CIR  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_IDLE = 3'b111
  } alu_op_e;

  // Ops that update CO/OVF; all of them also write E.
  function automatic logic op_is_arith(input alu_op_e op);
`ifdef AC_E_UNIT_SUB_EN
    return (op == ALU_ADD) || (op == ALU_SUB);
`else
    return (op == ALU_ADD);
`endif
  endfunction

  function automatic logic op_writes_e(input alu_op_e op);
    return op_is_arith(op) || (op == ALU_CIL) || (op == ALU_CIR);
  endfunction

endpackage

// File: rtl/ac_alu.sv
// Combinational ALU for the AC/E unit; idle (and SUB when AC_E_UNIT_SUB_EN is undefined)
// passes AC and E through unchanged.
module ac_alu
  import bc_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH
) (
  input  logic [WIDTH-1:0] ac,
  input  logic             e,
  input  logic [WIDTH-1:0] dr,
  input  alu_op_e          sel,
  output logic [WIDTH-1:0] result,
  output logic             e_next,
  output logic             carry,
  output logic             ovf
);

  logic             sub;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;

`ifdef AC_E_UNIT_SUB_EN
  assign sub = (sel == ALU_SUB);
`else
  assign sub = 1'b0;
`endif

  // One adder serves ADD and SUB: subtraction is AC + ~DR + 1, carry-out = no borrow.
  assign operand = sub ? ~dr : dr;
  assign sum     = {1'b0, ac} + {1'b0, operand} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    result = ac;
    e_next = e;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (sel)
      ALU_AND: result = ac & dr;
`ifdef AC_E_UNIT_SUB_EN
      ALU_ADD, ALU_SUB: begin
`else
      ALU_ADD: begin
`endif
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        e_next = sum[WIDTH];
        ovf    = (ac[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != ac[WIDTH-1]);
      end
      ALU_LDA: result = dr;
      ALU_CMA: result = ~ac;
      ALU_CIL: begin
        result = {ac[WIDTH-2:0], e};
        e_next = ac[WIDTH-1];
      end
      ALU_CIR: begin
        result = {e, ac[WIDTH-1:1]};
        e_next = ac[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ac_e_unit.sv
// Accumulator, extend bit and arithmetic flags of the basic computer datapath.
// Macro AC_E_UNIT_SUB_EN enables the SUB op (ALU_SEL 110); otherwise 110 is idle.
module ac_e_unit
  import bc_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] DR_IN,
  input  logic [2:0]       ALU_SEL,
  input  logic             LD_AC,
  input  logic             INR_AC,
  input  logic             CLR_AC,
  input  logic             CMP_E,
  input  logic             CLR_E,
  output logic [WIDTH-1:0] AC_OUT,
  output logic             E_OUT,
  output logic             CO,
  output logic             OVF,
  output logic             Z,
  output logic             N
);

  logic [WIDTH-1:0] ac_q;
  logic             e_q;
  logic             co_q;
  logic             ovf_q;

  alu_op_e          op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_e;
  logic             alu_carry;
  logic             alu_ovf;

  assign op = alu_op_e'(ALU_SEL);

  ac_alu #(.WIDTH(WIDTH)) u_alu (
    .ac     (ac_q),
    .e      (e_q),
    .dr     (DR_IN),
    .sel    (op),
    .result (alu_result),
    .e_next (alu_e),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_q  <= '0;
      e_q   <= 1'b0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (CLR_AC) begin
        ac_q <= '0;
      end else if (LD_AC) begin
        ac_q <= alu_result;
        if (op_is_arith(op)) begin
          co_q  <= alu_carry;
          ovf_q <= alu_ovf;
        end
      end else if (INR_AC) begin
        ac_q  <= ac_q + {{(WIDTH-1){1'b0}}, 1'b1};
        co_q  <= &ac_q;
        ovf_q <= (ac_q == {1'b0, {(WIDTH-1){1'b1}}});
      end

      // The ALU E write only lands when LD_AC actually won the AC priority.
      if (CLR_E) begin
        e_q <= 1'b0;
      end else if (CMP_E) begin
        e_q <= ~e_q;
      end else if (!CLR_AC && LD_AC && op_writes_e(op)) begin
        e_q <= alu_e;
      end
    end
  end

  assign AC_OUT = ac_q;
  assign E_OUT  = e_q;
  assign CO     = co_q;
  assign OVF    = ovf_q;
  assign Z      = (ac_q == '0);
  assign N      = ac_q[WIDTH-1];

endmodule

// File: tb/tb_ac_e_unit.sv
// Bench for ac_e_unit: directed scenarios with literal expectations plus random traffic,
// scored every cycle against an integer-arithmetic model of the AC/E rules.
module tb_ac_e_unit;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  DR_IN;
  logic [2:0]    ALU_SEL;
  logic          LD_AC, INR_AC, CLR_AC, CMP_E, CLR_E;
  logic [W-1:0]  AC_OUT;
  logic          E_OUT, CO, OVF, Z, N;

  ac_e_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .DR_IN   (DR_IN),
    .ALU_SEL (ALU_SEL),
    .LD_AC   (LD_AC),
    .INR_AC  (INR_AC),
    .CLR_AC  (CLR_AC),
    .CMP_E   (CMP_E),
    .CLR_E   (CLR_E),
    .AC_OUT  (AC_OUT),
    .E_OUT   (E_OUT),
    .CO      (CO),
    .OVF     (OVF),
    .Z       (Z),
    .N       (N)
  );

  // ---------------- clock/reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model + scoreboard ----------------
  // Packed observation: {AC, E, CO, OVF, Z, N}
  logic [20:0] exp_q[$];
  logic [20:0] dut_vec;
  logic [20:0] exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  int m_ac  = 0;
  bit m_e   = 1'b0;
  bit m_co  = 1'b0;
  bit m_ovf = 1'b0;

  assign dut_vec = {AC_OUT, E_OUT, CO, OVF, Z, N};

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic logic [20:0] model_vec();
    logic [15:0] a;
    a = m_ac[15:0];
    return {a, m_e, m_co, m_ovf, (m_ac == 0), (m_ac >= 32768)};
  endfunction

  task automatic model_step();
    int ac_n, s, ss, dr;
    bit e_n, co_n, ovf_n, alu_e_wr, alu_e;
    dr = int'(DR_IN);
    ac_n = m_ac; e_n = m_e; co_n = m_co; ovf_n = m_ovf;
    alu_e_wr = 1'b0; alu_e = 1'b0;
    if (!rst_n) begin
      m_ac = 0; m_e = 1'b0; m_co = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (CLR_AC) begin
      ac_n = 0;
    end else if (LD_AC) begin
      case (ALU_SEL)
        3'd0: ac_n = m_ac & dr;
        3'd1: begin
          s = m_ac + dr;
          ac_n = s % 65536;
          co_n = (s >= 65536);
          ss = to_signed(m_ac) + to_signed(dr);
          ovf_n = (ss > 32767) || (ss < -32768);
          alu_e_wr = 1'b1; alu_e = co_n;
        end
        3'd2: ac_n = dr;
        3'd3: ac_n = 65535 - m_ac;
        3'd4: begin
          ac_n = (m_ac * 2) % 65536 + int'(m_e);
          alu_e_wr = 1'b1; alu_e = (m_ac >= 32768);
        end
        3'd5: begin
          ac_n = m_ac / 2 + int'(m_e) * 32768;
          alu_e_wr = 1'b1; alu_e = (m_ac % 2 == 1);
        end
`ifdef AC_E_UNIT_SUB_EN
        3'd6: begin
          ac_n = (m_ac - dr + 65536) % 65536;
          co_n = (m_ac >= dr);
          ss = to_signed(m_ac) - to_signed(dr);
          ovf_n = (ss > 32767) || (ss < -32768);
          alu_e_wr = 1'b1; alu_e = co_n;
        end
`endif
        default: ;
      endcase
    end else if (INR_AC) begin
      ac_n = (m_ac + 1) % 65536;
      co_n = (m_ac == 65535);
      ovf_n = (m_ac == 32767);
    end
    if (CLR_E) e_n = 1'b0;
    else if (CMP_E) e_n = !m_e;
    else if (alu_e_wr) e_n = alu_e;
    m_ac = ac_n; m_e = e_n; m_co = co_n; m_ovf = ovf_n;
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ac,e,co,ovf,z,n}=%h_%b%b%b%b%b expected %h_%b%b%b%b%b", name,
               act[20:5], act[4], act[3], act[2], act[1], act[0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check("scoreboard", dut_vec, exp_v);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit rst, input bit ld, input bit inr, input bit clr,
                       input bit cmp, input bit clre, input logic [2:0] sel,
                       input logic [15:0] dr);
    rst_n = !rst; LD_AC = ld; INR_AC = inr; CLR_AC = clr;
    CMP_E = cmp; CLR_E = clre; ALU_SEL = sel; DR_IN = dr;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
  endtask

  task automatic ld(input logic [2:0] sel, input logic [15:0] dr);
    cycle(0, 1, 0, 0, 0, 0, sel, dr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset beats a concurrent load
    cycle(1, 1, 0, 0, 0, 0, 3'b010, 16'h1234);
    check("reset", dut_vec, {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    ld(3'b010, 16'hFFFF);
    ld(3'b001, 16'h0001);
    check("add_carry", dut_vec, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    ld(3'b010, 16'h7FFF);
    ld(3'b001, 16'h0001);
    check("add_ovf", dut_vec, {16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    ld(3'b010, 16'h8001);
    ld(3'b100, 16'h0000);
    check("cil", dut_vec, {16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    ld(3'b101, 16'h0000);
    check("cir", dut_vec, {16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    ld(3'b010, 16'h00F0);
    cycle(0, 1, 1, 1, 0, 0, 3'b001, 16'h0005);
    check("clr_priority", dut_vec, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    cycle(0, 0, 0, 0, 1, 1, 3'b111, 16'h0000);
    check("clre_priority", dut_vec, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    cycle(0, 0, 0, 0, 1, 0, 3'b111, 16'h0000);
    check("cmp_e", dut_vec, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

    ld(3'b010, 16'hFFFF);
    cycle(0, 0, 1, 0, 0, 0, 3'b000, 16'h0000);
    check("inr_wrap", dut_vec, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    ld(3'b111, 16'h1234);
    check("idle_hold", dut_vec, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

    ld(3'b010, 16'h0005);
    ld(3'b110, 16'h0007);
`ifdef AC_E_UNIT_SUB_EN
    check("sub", dut_vec, {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    check("sub_disabled", dut_vec, {16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
`endif

    // Random traffic; operands biased toward the carry/overflow corners
    for (int i = 0; i < 800; i++) begin
      logic [15:0] dr;
      case ($urandom_range(0, 5))
        0: dr = 16'hFFFF;
        1: dr = 16'h7FFF;
        2: dr = 16'h8000;
        3: dr = 16'h0001;
        default: dr = 16'($urandom_range(0, 65535));
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)), dr);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
